// File: rtl/prim_sel_pkg.sv
// Shared types and helpers for the pipelined primitive-select decoder.
// Holds default geometry, index-width helper and the table reset image.
package prim_sel_pkg;

  localparam int          N_SEL_DFLT    = 19;
  localparam int          W_OUT_DFLT    = 32;
  localparam logic [63:0] DEF_WORD_DFLT = 64'h0000_0000_0000_0008;

  // Width needed to encode 0..n, where n is the "no request" index.
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

  // One-hot word for a real primitive; the extra top entry holds the idle word.
  function automatic logic [63:0] tbl_rst(input int i, input int n_sel, input int w_out,
                                          input logic [63:0] def);
    if (i < n_sel) return 64'd1 << (i % w_out);
    return def;
  endfunction

endpackage

// File: rtl/prim_sel_decode_pipe_prio_enc.sv
// Combinational priority encoder: lowest set bit wins, flags empty and multi-hot vectors.
module prim_prio_enc
  import prim_sel_pkg::*;
#(
  parameter int N = 19
) (
  input  logic [N-1:0]          sel,
  output logic [idx_w(N)-1:0]   idx,
  output logic                  none,
  output logic                  multi
);

  localparam int IW = idx_w(N);

  // NOTE: every output of a combinational block gets a default before any
  // conditional update; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    idx = IW'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) idx = IW'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign none  = ~|sel;
  assign multi = |(sel & (sel - N'(1)));

endmodule

// File: rtl/prim_sel_decode_pipe.sv
// Two-stage valid/ready primitive-select decoder with a programmable control-word
// table and a saturating multi-hot request counter.
module prim_sel_decode_pipe
  import prim_sel_pkg::*;
#(
  parameter int               N_SEL    = N_SEL_DFLT,
  parameter int               W_OUT    = W_OUT_DFLT,
  parameter logic [W_OUT-1:0] DEF_WORD = W_OUT'(DEF_WORD_DFLT),
  parameter int               W_CNT    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_SEL-1:0]          sel_prim,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W_OUT-1:0]          prim_out,
  output logic [idx_w(N_SEL)-1:0]   prim_idx,
  output logic                      prim_multi,
  input  logic                      cfg_we,
  input  logic [idx_w(N_SEL)-1:0]   cfg_addr,
  input  logic [W_OUT-1:0]          cfg_data,
  input  logic                      stat_clr,
  output logic [W_CNT-1:0]          stat_multi
);

  localparam int IW = idx_w(N_SEL);

  logic             s1_valid_q, s1_valid_d;
  logic [N_SEL-1:0] s1_sel_q,   s1_sel_d;
  logic             s2_valid_q, s2_valid_d;
  logic [IW-1:0]    s2_idx_q,   s2_idx_d;
  logic             s2_multi_q, s2_multi_d;
  logic [W_OUT-1:0] s2_word_q,  s2_word_d;
  logic             out_valid_q, out_valid_d;
  logic [W_OUT-1:0] prim_out_q,  prim_out_d;
  logic [IW-1:0]    prim_idx_q,  prim_idx_d;
  logic             prim_multi_q, prim_multi_d;
  logic [W_CNT-1:0] stat_q, stat_d;
  logic [W_OUT-1:0] tbl_q [N_SEL+1];
  logic [W_OUT-1:0] tbl_d [N_SEL+1];

  logic          enc_none, enc_multi;
  logic [IW-1:0] enc_idx, lookup_idx;
  logic          out_load, s2_free, s1_free, accept, in_multi;

  prim_prio_enc #(.N(N_SEL)) u_enc (
    .sel   (s1_sel_q),
    .idx   (enc_idx),
    .none  (enc_none),
    .multi (enc_multi)
  );

  assign lookup_idx = enc_none ? IW'(N_SEL) : enc_idx;
  assign in_multi   = |(sel_prim & (sel_prim - N_SEL'(1)));

  // Each stage may load when it is empty or the stage below it is loading this cycle.
  assign out_load = !out_valid_q || out_ready;
  assign s2_free  = !s2_valid_q || out_load;
  assign s1_free  = !s1_valid_q || s2_free;
  assign in_ready = rst_n && s1_free;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sel_d     = s1_sel_q;
    s2_valid_d   = s2_valid_q;
    s2_idx_d     = s2_idx_q;
    s2_multi_d   = s2_multi_q;
    s2_word_d    = s2_word_q;
    out_valid_d  = out_valid_q;
    prim_out_d   = prim_out_q;
    prim_idx_d   = prim_idx_q;
    prim_multi_d = prim_multi_q;
    stat_d       = stat_q;
    tbl_d        = tbl_q;

    if (out_load) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        prim_out_d   = s2_word_q;
        prim_idx_d   = s2_idx_q;
        prim_multi_d = s2_multi_q;
      end
    end

    // The word is captured alongside idx so a same-edge table write is not seen.
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_idx_d   = lookup_idx;
        s2_multi_d = enc_multi;
        s2_word_d  = tbl_q[lookup_idx];
      end
    end

    if (s1_free) begin
      s1_valid_d = accept;
      if (accept) s1_sel_d = sel_prim;
    end

    if (stat_clr) begin
      stat_d = '0;
    end else if (accept && in_multi && stat_q != '1) begin
      stat_d = stat_q + W_CNT'(1);
    end

    if (cfg_we && cfg_addr <= IW'(N_SEL)) begin
      tbl_d[cfg_addr] = cfg_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sel_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_idx_q     <= '0;
      s2_multi_q   <= 1'b0;
      s2_word_q    <= '0;
      out_valid_q  <= 1'b0;
      prim_out_q   <= '0;
      prim_idx_q   <= '0;
      prim_multi_q <= 1'b0;
      stat_q       <= '0;
      // NOTE: the table is a register array that must come back to known contents
      // on reset, so every entry is reset explicitly; a plain RAM would not be.
      for (int i = 0; i <= N_SEL; i++) begin
        tbl_q[i] <= W_OUT'(tbl_rst(i, N_SEL, W_OUT, 64'(DEF_WORD)));
      end
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sel_q     <= s1_sel_d;
      s2_valid_q   <= s2_valid_d;
      s2_idx_q     <= s2_idx_d;
      s2_multi_q   <= s2_multi_d;
      s2_word_q    <= s2_word_d;
      out_valid_q  <= out_valid_d;
      prim_out_q   <= prim_out_d;
      prim_idx_q   <= prim_idx_d;
      prim_multi_q <= prim_multi_d;
      stat_q       <= stat_d;
      tbl_q        <= tbl_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign prim_out   = prim_out_q;
  assign prim_idx   = prim_idx_q;
  assign prim_multi = prim_multi_q;
  assign stat_multi = stat_q;

endmodule

// File: tb/tb_prim_sel_decode_pipe.sv
// Directed bench for prim_sel_decode_pipe: vector table plus hand-written
// sequences for saturation, table timing, backpressure and mid-stream reset.
module tb_prim_sel_decode_pipe;

  typedef struct {
    logic [18:0] sel;
    logic [31:0] word;
    logic [4:0]  idx;
    logic        multi;
    int          stat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, cfg_we, stat_clr;
  logic [18:0] sel_prim;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        in_ready, out_valid, prim_multi;
  logic [31:0] prim_out;
  logic [4:0]  prim_idx;
  logic [15:0] stat_multi;
  logic        in_ready2, out_valid2, prim_multi2;
  logic [31:0] prim_out2;
  logic [4:0]  prim_idx2;
  logic [1:0]  stat_multi2;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] tbl_m [20];
  vec_t        vecs [7];

  always #5 clk = ~clk;

  prim_sel_decode_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel_prim(sel_prim), .out_valid(out_valid), .out_ready(out_ready),
    .prim_out(prim_out), .prim_idx(prim_idx), .prim_multi(prim_multi),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .stat_clr(stat_clr), .stat_multi(stat_multi)
  );

  prim_sel_decode_pipe #(.W_CNT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .sel_prim(sel_prim), .out_valid(out_valid2), .out_ready(out_ready),
    .prim_out(prim_out2), .prim_idx(prim_idx2), .prim_multi(prim_multi2),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .stat_clr(stat_clr), .stat_multi(stat_multi2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 20; i++) tbl_m[i] = (i < 19) ? (32'd1 << i) : 32'h0000_0008;
  endtask

  // Single request on an empty pipe; checks readiness, latency and the result.
  task automatic run_vec(input vec_t v, input string name);
    int t;
    @(negedge clk);
    in_valid = 1'b1; sel_prim = v.sel; out_ready = 1'b1;
    #1;
    t = 0;
    while (!in_ready && t < 10) begin @(negedge clk); #1; t++; end
    check({name, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; sel_prim = '0;
    #1;
    t = 0;
    while (!out_valid && t < 10) begin @(negedge clk); #1; t++; end
    check({name, "_lat"}, t, 2);
    check({name, "_word"}, prim_out, v.word);
    check({name, "_idx"}, prim_idx, v.idx);
    check({name, "_multi"}, prim_multi, v.multi);
    check({name, "_stat"}, stat_multi, v.stat);
    check({name, "_stat2"}, stat_multi2, (v.stat > 3) ? 3 : v.stat);
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
    if (addr <= 5'd19) tbl_m[addr] = data;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent, rcv, cyc, acc_n, quiet;
    logic held, saw_block;
    logic [31:0] held_word;
    logic [4:0]  held_idx;

    vecs[0] = '{19'h00010, 32'h0000_0010, 5'd4,  1'b0, 0};
    vecs[1] = '{19'h00000, 32'h0000_0008, 5'd19, 1'b0, 0};
    vecs[2] = '{19'h40006, 32'h0000_0002, 5'd1,  1'b1, 1};
    vecs[3] = '{19'h40000, 32'h0004_0000, 5'd18, 1'b0, 1};
    vecs[4] = '{19'h7FFFF, 32'h0000_0001, 5'd0,  1'b1, 2};
    vecs[5] = '{19'h00001, 32'h0000_0001, 5'd0,  1'b0, 2};
    vecs[6] = '{19'h60000, 32'h0002_0000, 5'd17, 1'b1, 3};
    model_reset();

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0; stat_clr = 1'b0;
    sel_prim = '0; cfg_addr = '0; cfg_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_prim_out", prim_out, 0);
    check("rst_prim_idx", prim_idx, 0);
    check("rst_prim_multi", prim_multi, 0);
    check("rst_stat", stat_multi, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Keep pushing multi-hot requests: wide counter keeps counting, 2-bit one pins at 3.
    for (int k = 0; k < 5; k++) begin
      vec_t v;
      v = '{19'h00003, 32'h0000_0001, 5'd0, 1'b1, 4 + k};
      run_vec(v, $sformatf("sat%0d", k));
    end

    @(negedge clk);
    in_valid = 1'b1; sel_prim = 19'h00003; stat_clr = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; stat_clr = 1'b0; sel_prim = '0;
    #1;
    check("clr_stat", stat_multi, 0);
    check("clr_stat2", stat_multi2, 0);
    repeat (3) @(negedge clk);

    cfg_write(5'd19, 32'hDEAD_BEEF);
    run_vec('{19'h00000, 32'hDEAD_BEEF, 5'd19, 1'b0, 0}, "def_wr");
    cfg_write(5'd20, 32'h1234_5678);
    run_vec('{19'h00000, 32'hDEAD_BEEF, 5'd19, 1'b0, 0}, "oob_wr");

    // Entry 5 written on the edge the first bit5 request enters S2.
    @(negedge clk);
    in_valid = 1'b1; sel_prim = 19'h00020; out_ready = 1'b1;
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 5'd5; cfg_data = 32'hCAFE_0005;
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0; sel_prim = '0;
    tbl_m[5] = 32'hCAFE_0005;
    @(negedge clk); #1;
    check("rbw_old_valid", out_valid, 1);
    check("rbw_old_word", prim_out, 32'h0000_0020);
    @(negedge clk); #1;
    check("rbw_new_valid", out_valid, 1);
    check("rbw_new_word", prim_out, 32'hCAFE_0005);
    @(negedge clk);

    // Stream 8 one-hot requests under out_ready pattern 1,0,0,1.
    sent = 0; rcv = 0; cyc = 0; held = 1'b0; saw_block = 1'b0;
    held_word = '0; held_idx = '0;
    while (rcv < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 8);
      sel_prim  = (sent < 8) ? (19'd1 << sent) : '0;
      #1;
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_word", prim_out, held_word);
        check("hold_idx", prim_idx, held_idx);
      end
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (out_valid && out_ready) begin
        check($sformatf("stream_word%0d", rcv), prim_out, tbl_m[rcv]);
        check($sformatf("stream_idx%0d", rcv), prim_idx, rcv);
        rcv++;
      end
      held = out_valid && !out_ready;
      held_word = prim_out; held_idx = prim_idx;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    check("stream_count", rcv, 8);
    check("stream_block", saw_block, 1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("stream_drained", out_valid, 0);

    // With the output stalled from empty, exactly three requests fit.
    acc_n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; sel_prim = 19'd1 << (9 + acc_n);
      #1;
      if (in_ready) acc_n++;
    end
    check("fill_count", acc_n, 3);
    check("fill_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0; sel_prim = '0; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drain_valid%0d", k), out_valid, 1);
      check($sformatf("drain_idx%0d", k), prim_idx, 9 + k);
      @(negedge clk); #1;
    end
    check("drain_empty", out_valid, 0);

    // Reset with two requests in flight.
    @(negedge clk);
    in_valid = 1'b1; sel_prim = 19'h00000;
    @(negedge clk);
    sel_prim = 19'h00020;
    @(negedge clk);
    in_valid = 1'b0; sel_prim = '0; rst_n = 1'b0;
    #1;
    check("mrst_in_ready", in_ready, 0);
    @(negedge clk); #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_prim_out", prim_out, 0);
    check("mrst_stat", stat_multi, 0);
    rst_n = 1'b1;
    quiet = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (out_valid) quiet++;
    end
    check("mrst_no_stale", quiet, 0);
    model_reset();
    run_vec('{19'h00000, 32'h0000_0008, 5'd19, 1'b0, 0}, "mrst_def");
    run_vec('{19'h00020, 32'h0000_0020, 5'd5,  1'b0, 0}, "mrst_e5");

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
